// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Produces packed BCD digits plus a sticky overflow when the value needs more than DIGITS digits.
module bin_to_bcd #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int DW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [DW-1:0]      dig_q, dig_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [DW-1:0]      dig_adj;
    logic [DW-1:0]      dig_sh;
    logic [BIN_W-1:0]   bin_sh;
    logic               shift_out;

    // Each digit is corrected independently; carries only appear through the following shift.
    function automatic logic [DW-1:0] add3_adjust(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        for (int k = 0; k < DIGITS; k++) begin
            if (d[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = d[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign dig_adj = add3_adjust(dig_q);
    assign {shift_out, dig_sh, bin_sh} = {dig_adj, bin_q, 1'b0};

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        dig_d    = dig_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d    = bin;
                    dig_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CNT_W'(BIN_W);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                bin_d    = bin_sh;
                dig_d    = dig_sh;
                sticky_d = sticky_q | shift_out;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = dig_sh;
                    ovf_d   = sticky_q | shift_out;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            dig_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            dig_q    <= dig_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: a 3-digit and a 2-digit instance share clock and reset.
// Stimulus pushes expected results; per-instance monitors pop and compare on every done pulse.
module tb_bin_to_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start3 = 1'b0, start2 = 1'b0;
    logic [7:0]  bin3 = '0, bin2 = '0;
    logic        busy3, done3, ovf3;
    logic        busy2, done2, ovf2;
    logic [11:0] bcd3;
    logic [7:0]  bcd2;

    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t q3[$];
    exp_t q2[$];
    exp_t e3, e2;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   prev_done3 = 0, prev_done2 = 0;

    always #5 clk = ~clk;

    bin_to_bcd #(.BIN_W(8), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .bin(bin3),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
    );

    bin_to_bcd #(.BIN_W(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic bit digits_ok(input logic [11:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            if (b[4*k +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [11:0] dec_model(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    always @(negedge clk) begin
        if (done3) begin
            check("done_busy_excl3", {31'd0, busy3}, 32'd0);
            check("done_pulse3", {31'd0, prev_done3}, 32'd0);
            if (q3.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done3: bcd=%h with no result expected", bcd3);
            end else begin
                e3 = q3.pop_front();
                check("bcd3", {20'd0, bcd3}, {20'd0, e3.bcd});
                check("ovf3", {31'd0, ovf3}, {31'd0, e3.ovf});
                check("digits3", {31'd0, digits_ok(bcd3, 3)}, 32'd1);
            end
        end
        prev_done3 = done3;
    end

    always @(negedge clk) begin
        if (done2) begin
            check("done_busy_excl2", {31'd0, busy2}, 32'd0);
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done2: bcd=%h with no result expected", bcd2);
            end else begin
                e2 = q2.pop_front();
                check("bcd2", {24'd0, bcd2}, {20'd0, e2.bcd});
                check("ovf2", {31'd0, ovf2}, {31'd0, e2.ovf});
                check("digits2", {31'd0, digits_ok({4'd0, bcd2}, 2)}, 32'd1);
            end
        end
        prev_done2 = done2;
    end

    // Drive start now (caller is away from a clock edge) and register the expectation.
    task automatic issue(input bit d2, input logic [7:0] b, input logic [11:0] eb, input logic eo);
        if (d2) begin
            start2 = 1'b1;
            bin2   = b;
            q2.push_back('{bcd: eb, ovf: eo});
        end else begin
            start3 = 1'b1;
            bin3   = b;
            q3.push_back('{bcd: eb, ovf: eo});
        end
    endtask

    // Count edges from acceptance to done; optionally poke a start (bin=7) into dut3 mid-conversion.
    task automatic wait_done(input bit d2, input int poke);
        int  busy_cnt = 0;
        int  lat      = 0;
        bit  seen     = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                start3 = 1'b0;
                start2 = 1'b0;
            end
            if (poke > 0 && i == poke) begin
                start3 = 1'b1;
                bin3   = 8'd7;
            end
            if (poke > 0 && i == poke + 1) start3 = 1'b0;
            if (d2 ? done2 : done3) begin
                seen = 1;
                lat  = i;
            end else if (d2 ? busy2 : busy3) begin
                busy_cnt++;
            end
        end
        check("latency", lat, 9);
        check("busy_cycles", busy_cnt, 8);
    endtask

    logic [7:0]  dir_bin [3] = '{8'd0, 8'd99, 8'd10};
    logic [11:0] dir_bcd [3] = '{12'h000, 12'h099, 12'h010};

    initial begin
        int seen_d;
        #2 rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy3}, 32'd0);
        check("rst_done", {31'd0, done3}, 32'd0);
        check("rst_bcd", {20'd0, bcd3}, 32'd0);
        check("rst_ovf", {31'd0, ovf3}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue(0, 8'd255, 12'h255, 1'b0);
        wait_done(0, 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue(0, dir_bin[i], dir_bcd[i], 1'b0);
            wait_done(0, 0);
        end

        @(negedge clk);
        issue(0, 8'd128, 12'h128, 1'b0);
        wait_done(0, 4);
        issue(0, 8'd7, 12'h007, 1'b0);
        wait_done(0, 0);

        @(negedge clk);
        issue(0, 8'd200, 12'h200, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start3 = 1'b0;
        end
        #3 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy3}, 32'd0);
        check("abort_done", {31'd0, done3}, 32'd0);
        check("abort_bcd", {20'd0, bcd3}, 32'd0);
        q3.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_d = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done3) seen_d++;
        end
        check("no_done_after_abort", seen_d, 0);
        @(negedge clk);
        issue(0, 8'd200, 12'h200, 1'b0);
        wait_done(0, 0);

        @(negedge clk);
        issue(1, 8'd255, 12'h055, 1'b1);
        wait_done(1, 0);
        @(negedge clk);
        issue(1, 8'd42, 12'h042, 1'b0);
        wait_done(1, 0);

        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            issue(0, 8'(v), dec_model(v), 1'b0);
            wait_done(0, 0);
        end

        repeat (3) @(negedge clk);
        check("queue3_drained", q3.size(), 0);
        check("queue2_drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It converts one unsigned binary operand into packed BCD digits at one input bit per clock. It sits directly upstream of the BCD digit adder and supplies its BCD operand digits (A/B), which are taken from the packed `bcd` output. It has a start/busy/done handshake so a controller can sequence conversions ahead of BCD arithmetic.

## Interface
- `BIN_W`, default 8: width of the binary input; also the number of shift cycles per conversion.
- `DIGITS`, default 3: number of BCD output digits; output width is 4*DIGITS.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high.
- `start`  in  1  request a conversion; sampled on the rising edge of `clk`.
- `bin`  in  BIN_W  unsigned binary operand; captured on the edge that accepts `start`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; `bcd` and `overflow` are valid and newly updated.
- `bcd`  out  4*DIGITS  packed BCD result; digit 0 is in [3:0]; holds its value until the next completion.
- `overflow`  out  1  the value needed more than DIGITS digits; valid with `done`, holds with `bcd`.

## Operation
- States: IDLE and SHIFT.
- IDLE with `start`=1 at an edge:
  - latch `bin` into the shift register;
  - clear the scratch digits and the sticky overflow;
  - load the bit counter with BIN_W;
  - go to SHIFT.
- IDLE with `start`=0: hold.
- SHIFT, every edge, in this order:
  1. Any scratch digit ≥5 gets +3. Each digit is 4-bit and its adjust does not depend on the other digits.
  2. Shift the concatenation {digits, binary} left by 1.
  3. Decrement the counter.
- Overflow: the bit shifted out of the top digit is ORed into the sticky overflow.
- Last shift (counter 1→0):
  - copy the scratch digits to `bcd` and the sticky value to `overflow`;
  - pulse `done`;
  - return to IDLE.
- Truncation: when overflow=1, `bcd` equals the low DIGITS decimal digits of the value, because digit adjustments only propagate upward. Example: DIGITS=2, bin=255 gives bcd=0x55.
- `start` during SHIFT is ignored. There is no queueing.
- `bin` changes after acceptance have no effect.
- Every `bcd` digit is always ≤9.

## Timing
- Reset (async assert, takes effect immediately):
  - state=IDLE, `busy`=0, `done`=0, `bcd`=0, `overflow`=0;
  - counter and scratch cleared.
- Release: the first rising edge with `rst`=0 is the first functional edge.
- Acceptance edge E0 (start=1 in IDLE): `busy` goes high after E0.
- Shifts occur on edges E1..E_BIN_W.
- On edge E_BIN_W:
  - `busy` goes low;
  - `done` goes high for exactly one cycle;
  - `bcd` and `overflow` update.
- Latency: BIN_W+1 edges from the acceptance edge to `done` visible. This is 9 cycles for BIN_W=8.
- Back-to-back: the cycle in which `done`=1 is an IDLE cycle.
  - `start`=1 there is accepted on the next edge.
  - Sustained throughput is one result per BIN_W+1 cycles.
- Reset mid-conversion:
  - aborts immediately, with no `done`;
  - `bcd` is forced to 0;
  - a new `start` is accepted on the first edge after release.
- `done` and `busy` are never high in the same cycle.

## Test plan
- Reset, then start with bin=255 (BIN_W=8, DIGITS=3) -> `busy` high for 8 cycles; `done` on the 9th edge; bcd=0x255, overflow=0.
- bin=0, then bin=99, then bin=10 -> bcd=0x000, then 0x099, then 0x010; each with a single-cycle `done`.
- Start bin=128; assert `start` with bin=7 while busy; then start bin=7 in the `done` cycle -> first result 0x128, the mid-conversion start is ignored, second result 0x007 nine edges later.
- Assert `rst` asynchronously 4 cycles into converting bin=200 -> busy=0, done=0, bcd=0 immediately; no `done` follows; a new start with bin=200 gives 0x200.
- DIGITS=2, bin=255 -> done with overflow=1, bcd=0x55; a following bin=42 gives overflow=0, bcd=0x42.
- Sweep bin=0..255 -> `bcd` matches the decimal value and every digit is ≤9.
